// File: rtl/rx_fifo_if.sv
// Handshake bundle between the ISR/bus side and the receive FIFO.
interface rx_fifo_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int LW = $clog2(2 * DEPTH) + 1;

  logic [WIDTH-1:0] in_pushData;
  logic             in_push;
  logic             in_pop;
  logic             in_join;
  logic             in_clearFlags;
  logic [WIDTH-1:0] out_data;
  logic             out_empty;
  logic             out_full;
  logic [LW-1:0]    out_level;
  logic             out_overflow;
  logic             out_underflow;

  modport master (
    output in_pushData, in_push, in_pop, in_join, in_clearFlags,
    input  out_data, out_empty, out_full, out_level, out_overflow, out_underflow
  );

  modport slave (
    input  in_pushData, in_push, in_pop, in_join, in_clearFlags,
    output out_data, out_empty, out_full, out_level, out_overflow, out_underflow
  );
endinterface

// File: rtl/rx_fifo.sv
// openPIO receive FIFO: FWFT buffer behind the ISR, with sticky error flags and
// a join mode that doubles capacity using the borrowed TX storage.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  rx_fifo_if.slave fifo
);
  localparam int CAP2 = 2 * DEPTH;
  localparam int PW   = $clog2(CAP2);
  localparam int LW   = PW + 1;
  localparam logic [LW-1:0] CAP_NORM = LW'(DEPTH);
  localparam logic [LW-1:0] CAP_JOIN = LW'(CAP2);

  logic [WIDTH-1:0] mem_r [CAP2];
  logic [PW-1:0]    wrPtr_r, rdPtr_r, wrPtrNext_s, rdPtrNext_s;
  logic [LW-1:0]    level_r, levelNext_s, capacity_s, capacityNext_s;
  logic             join_r, empty_r, full_r, overflow_r, underflow_r;
  logic             joinChange_s, pushAcc_s, popAcc_s, overflowEv_s, underflowEv_s;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr, input logic [LW-1:0] cap);
    if ({1'b0, ptr} == (cap - LW'(1))) begin
      return '0;
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Acceptance decisions and next-state for pointers and level
  always_comb begin
    capacity_s     = join_r ? CAP_JOIN : CAP_NORM;
    capacityNext_s = fifo.in_join ? CAP_JOIN : CAP_NORM;
    joinChange_s   = (fifo.in_join != join_r);
    popAcc_s       = fifo.in_pop && (level_r != '0) && !joinChange_s;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    pushAcc_s      = fifo.in_push && !joinChange_s && ((level_r < capacity_s) || popAcc_s);
    overflowEv_s   = fifo.in_push && !joinChange_s && !pushAcc_s;
    underflowEv_s  = fifo.in_pop && !joinChange_s && (level_r == '0);
    wrPtrNext_s    = wrPtr_r;
    rdPtrNext_s    = rdPtr_r;
    levelNext_s    = level_r;
    if (joinChange_s) begin
      wrPtrNext_s = '0;
      rdPtrNext_s = '0;
      levelNext_s = '0;
    end else begin
      if (pushAcc_s) begin
        wrPtrNext_s = advance(wrPtr_r, capacity_s);
      end else begin
        wrPtrNext_s = wrPtr_r;
      end
      if (popAcc_s) begin
        rdPtrNext_s = advance(rdPtr_r, capacity_s);
      end else begin
        rdPtrNext_s = rdPtr_r;
      end
      case ({pushAcc_s, popAcc_s})
        2'b10:   levelNext_s = level_r + LW'(1);
        2'b01:   levelNext_s = level_r - LW'(1);
        default: levelNext_s = level_r;
      endcase
    end
  end

  // Control state, status and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_r     <= '0;
      rdPtr_r     <= '0;
      level_r     <= '0;
      join_r      <= 1'b0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wrPtr_r     <= wrPtrNext_s;
      rdPtr_r     <= rdPtrNext_s;
      level_r     <= levelNext_s;
      join_r      <= fifo.in_join;
      empty_r     <= (levelNext_s == '0);
      full_r      <= (levelNext_s == capacityNext_s);
      overflow_r  <= overflowEv_s  ? 1'b1 : (fifo.in_clearFlags ? 1'b0 : overflow_r);
      underflow_r <= underflowEv_s ? 1'b1 : (fifo.in_clearFlags ? 1'b0 : underflow_r);
    end
  end

  // Storage array; contents survive reset, visibility is gated by empty
  always_ff @(posedge clk) begin
    if (pushAcc_s) begin
      mem_r[wrPtr_r] <= fifo.in_pushData;
    end
  end

  assign fifo.out_data      = empty_r ? '0 : mem_r[rdPtr_r];
  assign fifo.out_empty     = empty_r;
  assign fifo.out_full      = full_r;
  assign fifo.out_level     = level_r;
  assign fifo.out_overflow  = overflow_r;
  assign fifo.out_underflow = underflow_r;
endmodule

// File: tb/tb_rx_fifo.sv
// Directed scoreboard bench for rx_fifo.
module tb_rx_fifo;
  logic clk;
  logic reset;
  logic j;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb[$];
  logic        modelJoin;
  logic        expOvf;
  logic        expUnf;

  rx_fifo_if #(.DEPTH(4), .WIDTH(32)) f ();

  rx_fifo #(.DEPTH(4), .WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .fifo (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    chk({tag, "_level"}, 32'(f.out_level), 32'(sb.size()));
    chk({tag, "_empty"}, 32'(f.out_empty), 32'(sb.size() == 0));
    chk({tag, "_full"},  32'(f.out_full),  32'(sb.size() == (modelJoin ? 8 : 4)));
    chk({tag, "_data"},  f.out_data, (sb.size() == 0) ? 32'h0 : sb[0]);
    chk({tag, "_ovf"},   32'(f.out_overflow),  32'(expOvf));
    chk({tag, "_unf"},   32'(f.out_underflow), 32'(expUnf));
  endtask

  task automatic cycle(input logic push, input logic [31:0] d, input logic pop, input logic clr);
    logic joinChg;
    logic popOk;
    logic pushOk;
    logic wasEmpty;
    int   cap;
    joinChg  = (j != modelJoin);
    cap      = modelJoin ? 8 : 4;
    wasEmpty = (sb.size() == 0);
    popOk    = pop && !wasEmpty && !joinChg;
    pushOk   = push && !joinChg && ((sb.size() < cap) || popOk);
    if (popOk) chk("pop_head", f.out_data, sb[0]);
    f.in_push       = push;
    f.in_pushData   = d;
    f.in_pop        = pop;
    f.in_clearFlags = clr;
    f.in_join       = j;
    @(posedge clk);
    #1;
    f.in_push       = 1'b0;
    f.in_pop        = 1'b0;
    f.in_clearFlags = 1'b0;
    if (joinChg) begin
      sb.delete();
    end else begin
      if (popOk) void'(sb.pop_front());
      if (pushOk) sb.push_back(d);
    end
    expOvf    = (push && !joinChg && !pushOk) ? 1'b1 : (clr ? 1'b0 : expOvf);
    expUnf    = (pop && !joinChg && wasEmpty) ? 1'b1 : (clr ? 1'b0 : expUnf);
    modelJoin = j;
    checkModel("cyc");
  endtask

  initial begin
    reset = 1'b1;
    j = 1'b0;
    modelJoin = 1'b0;
    expOvf = 1'b0;
    expUnf = 1'b0;
    f.in_pushData = 32'h0;
    f.in_push = 1'b0;
    f.in_pop = 1'b0;
    f.in_join = 1'b0;
    f.in_clearFlags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(f.out_empty), 32'd1);
    chk("rst_full",  32'(f.out_full),  32'd0);
    chk("rst_level", 32'(f.out_level), 32'd0);
    chk("rst_data",  f.out_data, 32'h0);
    chk("rst_ovf",   32'(f.out_overflow),  32'd0);
    chk("rst_unf",   32'(f.out_underflow), 32'd0);
    reset = 1'b0;

    // Basic ordering
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0);
    chk("basic_first_visible", f.out_data, 32'h11111111);
    cycle(1'b1, 32'h22222222, 1'b0, 1'b0);
    cycle(1'b1, 32'h33333333, 1'b0, 1'b0);
    cycle(1'b1, 32'h44444444, 1'b0, 1'b0);
    chk("basic_full",  32'(f.out_full),  32'd1);
    chk("basic_level", 32'(f.out_level), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("basic_drained_empty", 32'(f.out_empty), 32'd1);
    chk("basic_drained_data",  f.out_data, 32'h0);

    // Underflow with simultaneous push
    cycle(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    chk("unf_flag",  32'(f.out_underflow), 32'd1);
    chk("unf_level", 32'(f.out_level), 32'd1);
    chk("unf_data",  f.out_data, 32'hA5A5A5A5);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("unf_cleared", 32'(f.out_underflow), 32'd0);

    // Overflow then clear
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("ovf_flag",  32'(f.out_overflow), 32'd1);
    chk("ovf_level", 32'(f.out_level), 32'd4);
    chk("ovf_head",  f.out_data, 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(f.out_overflow), 32'd0);

    // Push and pop together while full
    cycle(1'b1, 32'h55, 1'b1, 1'b0);
    chk("fullsim_level", 32'(f.out_level), 32'd4);
    chk("fullsim_ovf",   32'(f.out_overflow), 32'd0);
    chk("fullsim_head",  f.out_data, 32'h2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fullsim_empty", 32'(f.out_empty), 32'd1);

    // Join change flushes, then doubled capacity
    cycle(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
    j = 1'b1;
    cycle(1'b1, 32'hBBBBBBBB, 1'b1, 1'b0);
    chk("join_flush_level", 32'(f.out_level), 32'd0);
    chk("join_flush_unf",   32'(f.out_underflow), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    chk("join_full",  32'(f.out_full),  32'd1);
    chk("join_level", 32'(f.out_level), 32'd8);
    cycle(1'b1, 32'h99, 1'b0, 1'b0);
    chk("join_ovf", 32'(f.out_overflow), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    // Keep traffic flowing so both pointers cross the 8-entry wrap
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("join_drained", 32'(f.out_empty), 32'd1);

    // Back to normal mode, then async reset mid-stream
    j = 1'b0;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_empty", 32'(f.out_empty), 32'd1);
    chk("arst_level", 32'(f.out_level), 32'd0);
    chk("arst_data",  f.out_data, 32'h0);
    chk("arst_ovf",   32'(f.out_overflow), 32'd0);
    chk("arst_full",  32'(f.out_full), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    expOvf = 1'b0;
    expUnf = 1'b0;
    modelJoin = 1'b0;
    cycle(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    chk("arst_after_push", f.out_data, 32'hCAFEF00D);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive FIFO that sits directly downstream of the input shift register (ISR) in each openPIO state machine. It captures every 32-bit word the ISR pushes, explicitly via PUSH or through auto-push, and buffers it until the system-bus side pops it. It provides first-word-fall-through read data, full/empty/level status for stalling the state machine, and sticky overflow/underflow flags. A join mode doubles the capacity by borrowing the unused TX storage.

## Interface
- DEPTH, 4, entries in normal mode; capacity is 2*DEPTH when joined; power of two, ≥2
- WIDTH, 32, word width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_pushData  input  WIDTH  word from the ISR, sampled when in_push=1
- in_push  input  1  push request from the ISR / PUSH instruction
- in_pop  input  1  pop request from the bus side
- in_join  input  1  1 = joined mode, capacity 2*DEPTH
- in_clearFlags  input  1  clears out_overflow and out_underflow
- out_data  output  WIDTH  head entry (FWFT); 0 when empty
- out_empty  output  1  level == 0
- out_full  output  1  level == capacity; the state machine stalls a blocking PUSH on this
- out_level  output  clog2(2*DEPTH)+1  current occupancy
- out_overflow  output  1  sticky; set when a push is dropped
- out_underflow  output  1  sticky; set when a pop hits an empty FIFO

## Operation
- Storage is always 2*DEPTH entries. Capacity is DEPTH when in_join=0 and 2*DEPTH when in_join=1.
- Pointers:
  - Read and write pointers are clog2(2*DEPTH) bits wide.
  - In normal mode they wrap at DEPTH; in joined mode they wrap at 2*DEPTH.
  - out_level is a separate counter.
- Accepted push: in_push=1 and (level < capacity, or an accepted pop happens in the same cycle). The word is written at wptr and wptr advances.
- Accepted pop: in_pop=1 and level > 0. rptr advances.
- Push while full with no pop: the word is dropped, state is unchanged, and out_overflow is set next cycle.
- Pop while empty: nothing is dequeued and out_underflow is set next cycle. A push in the same cycle is still accepted; there is no bypass, so out_data shows it from the next cycle.
- Push and pop together with 0 < level < capacity: both are accepted and the level is unchanged.
- Push and pop together while full: both are accepted, the level stays at capacity, and no overflow is flagged.
- Level update: level_next = level + pushAcc − popAcc.
- out_data = mem[rptr] when !empty, otherwise 0. It is combinational from registered state only; it has no combinational path from in_pushData.
- Join change:
  - A change of in_join is detected against a registered copy of in_join.
  - In that cycle the FIFO flushes: pointers and level go to 0.
  - A push or pop in that cycle is ignored and sets no flags.
  - The sticky flags are preserved.
  - The new capacity applies from the next cycle.
- in_clearFlags:
  - Clears both sticky flags on the next edge.
  - If a new overflow or underflow occurs in the same cycle, the set wins.

## Timing
- Reset (asynchronous assert, synchronous-edge release): pointers, level, both flags and the registered join copy (loaded with 0) are all cleared.
  - Outputs during reset: out_empty=1, out_full=0, out_level=0, out_data=0, out_overflow=0, out_underflow=0.
- Reset mid-operation discards all contents immediately. Memory contents need not be cleared, but out_data must read 0 while empty.
- Push-to-visible latency is 1 cycle: a word pushed at edge N appears on out_data and out_level after edge N if the FIFO was empty.
- Pop takes effect at the edge: the next entry, or 0, is presented after that edge.
- out_full, out_empty and out_level are registered-state-derived and glitch-free relative to inputs. The ISR side must not see a combinational path from in_pop to out_full.
- Throughput is one push and one pop per cycle, sustained indefinitely.

## Test plan
- Basic ordering:
  - Stimulus: after reset, push 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
  - Required response: out_full=1 and out_level=4. Four pops then return the words in order. After the last pop, out_empty=1 and out_data=0.
- Overflow:
  - Stimulus: fill 4 entries, push 0xDEADBEEF, then pulse in_clearFlags for one cycle.
  - Required response: the word is dropped, out_level stays 4 and out_overflow=1. The contents are unchanged. The clear pulse takes the flag back to 0.
- Underflow:
  - Stimulus: pop while empty and push 0xA5A5A5A5 in the same cycle.
  - Required response: out_underflow=1, out_level=1 and out_data=0xA5A5A5A5 next cycle.
- Full simultaneous:
  - Stimulus: with the FIFO full, push 0x55 and pop together.
  - Required response: out_level stays 4 and no overflow is flagged. Draining yields entries 2–4 followed by 0x55.
- Join:
  - Stimulus: set in_join=1 while holding 2 entries, then push 8 words 0..7, then push 0x99.
  - Required response: the join change flushes to level 0. The 8 pushes reach out_full=1 with out_level=8. The extra push sets out_overflow. Draining returns 0..7 in order, wrapping correctly at 8.
- Async reset mid-stream:
  - Stimulus: with 3 entries held, assert reset between clock edges.
  - Required response: outputs go to reset values immediately, without waiting for an edge. After release, the first push is read back correctly.
